// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample driver: FSM state encodings, default widths
// and the FIR core ready/busy handshake levels.
package fir_pkg;

    localparam int FIR_DATA_W = 16;
    localparam int FIR_WDOG_W = 8;

    localparam logic FIR_CORE_IDLE = 1'b1;
    localparam logic FIR_CORE_BUSY = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_DONE      = 3'd4
    } fir_state_e;

    function automatic logic fir_is_waiting(input fir_state_e st);
        return (st == ST_WAIT_LOW) || (st == ST_WAIT_HIGH);
    endfunction

endpackage

// File: rtl/fir_sample_driver_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head; simultaneous push and pop
// are both honoured, a push while full is dropped.
module sync_fifo
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_push_data,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == {LW{1'b0}});
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Storage array; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= {LW{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/fir_sample_driver.sv
// Initiator side of the act/ready FIR handshake: queues samples, launches one computation
// at a time and returns each result as a one-cycle pulse. Watchdog: FIR_DRV_TIMEOUT_EN.
module fir_sample_driver
    import fir_pkg::*;
#(
    parameter int DATA_W      = FIR_DATA_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 63
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DATA_W-1:0]             fir_x,
    output logic                          fir_act,
    input  logic                          fir_ready,
    input  logic [DATA_W-1:0]             fir_y,
    output logic [DATA_W-1:0]             out_y,
    output logic                          out_valid,
    output logic                          busy,
    output logic                          err
);

    fir_state_e         r_state;
    logic [DATA_W-1:0]  r_x;
    logic [DATA_W-1:0]  r_y;
    logic               r_act;
    logic               r_valid;
    logic               r_busy;

    logic [DATA_W-1:0]  w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_step_low;
    logic               w_step_high;
    logic               w_abort;

    assign w_pop       = (r_state == ST_IDLE) && !w_empty && (fir_ready == FIR_CORE_IDLE);
    assign w_step_low  = (r_state == ST_WAIT_LOW) && (fir_ready == FIR_CORE_BUSY);
    assign w_step_high = (r_state == ST_WAIT_HIGH) && (fir_ready == FIR_CORE_IDLE);

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (in_valid),
        .i_push_data (in_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (fifo_level)
    );

`ifdef FIR_DRV_TIMEOUT_EN
    localparam logic [FIR_WDOG_W-1:0] TMO_LAST = FIR_WDOG_W'(TIMEOUT_CYC - 1);

    logic [FIR_WDOG_W-1:0] r_wdog;
    logic                  r_err;

    // A core answer in the same cycle as expiry still completes normally.
    assign w_abort = fir_is_waiting(r_state) && (r_wdog == TMO_LAST) && !w_step_low && !w_step_high;
    assign err     = r_err;

    // Watchdog counts only while waiting on the core.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog <= {FIR_WDOG_W{1'b0}};
        end else if (r_state == ST_LAUNCH) begin
            r_wdog <= {FIR_WDOG_W{1'b0}};
        end else if (fir_is_waiting(r_state)) begin
            r_wdog <= r_wdog + FIR_WDOG_W'(1);
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_abort) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_abort = 1'b0;
    assign err     = 1'b0;
`endif

    assign in_ready  = ~w_full;
    assign fir_x     = r_x;
    assign fir_act   = r_act;
    assign out_y     = r_y;
    assign out_valid = r_valid;
    assign busy      = r_busy;

    // Handshake FSM; act, valid and busy are registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_x     <= {DATA_W{1'b0}};
            r_y     <= {DATA_W{1'b0}};
            r_act   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                    if (w_pop) begin
                        r_x     <= w_head;
                        r_act   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_LAUNCH;
                    end else begin
                        r_act  <= 1'b0;
                        r_busy <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    r_act   <= 1'b0;
                    r_state <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (w_step_low) begin
                        r_state <= ST_WAIT_HIGH;
                    end else if (w_abort) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (w_step_high) begin
                        r_y     <= fir_y;
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_abort) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_act   <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sample_driver.sv
// Scoreboard bench for fir_sample_driver with a behavioural multicycle FIR core model.
`timescale 1ns/1ps
module tb_fir_sample_driver;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] fifo_level;
    logic [DW-1:0] fir_x;
    logic          fir_act;
    logic          fir_ready;
    logic [DW-1:0] fir_y;
    logic [DW-1:0] out_y;
    logic          out_valid;
    logic          busy;
    logic          err;

    fir_sample_driver #(
        .DATA_W      (DW),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (63)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fifo_level (fifo_level),
        .fir_x      (fir_x),
        .fir_act    (fir_act),
        .fir_ready  (fir_ready),
        .fir_y      (fir_y),
        .out_y      (out_y),
        .out_valid  (out_valid),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Core model: ready drops on the edge that sees act, returns core_n cycles later.
    logic          m_ready;
    logic [DW-1:0] m_x;
    logic [DW-1:0] m_y;
    int            m_cnt;
    logic          hang;
    logic          force_low;
    int            core_n;
    int            cyc;

    assign fir_ready = m_ready & ~force_low;
    assign fir_y     = m_y;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ready <= 1'b1;
            m_cnt   <= 0;
            m_x     <= '0;
            m_y     <= '0;
        end else if (fir_act) begin
            m_ready <= 1'b0;
            m_cnt   <= core_n;
            m_x     <= fir_x;
        end else if (!m_ready && !hang) begin
            if (m_cnt <= 1) begin
                m_ready <= 1'b1;
                m_y     <= m_x ^ 16'h1ABC;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    int n_act  = 0;
    int n_out  = 0;
    int n_unstable = 0;
    int n_full = 0;
    int max_level = 0;
    int t_act  = 0;
    logic [DW-1:0] xq[$];
    logic [DW-1:0] yq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboards on act and on out_valid.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
                if (fir_act) begin
                    n_act++;
                    t_act = cyc;
                    check_eq("act_core_idle", {31'd0, m_ready}, 32'd1);
                    check_eq("act_has_sample", {31'd0, xq.size() > 0}, 32'd1);
                    if (xq.size() > 0) check_eq("fir_x_order", {16'd0, fir_x}, {16'd0, xq.pop_front()});
                end
                if (out_valid) begin
                    n_out++;
                    check_eq("out_has_expect", {31'd0, yq.size() > 0}, 32'd1);
                    if (yq.size() > 0) check_eq("out_y", {16'd0, out_y}, {16'd0, yq.pop_front()});
                end
                if (busy && !m_ready && fir_x !== m_x) n_unstable++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [DW-1:0] x, input bit expect_out);
        int guard;
        guard = 0;
        @(negedge clk);
        in_data  = x;
        in_valid = 1'b1;
        while (!in_ready && guard < 500) begin
            n_full++;
            check_eq("full_level", {29'd0, fifo_level}, DEPTH);
            @(negedge clk);
            guard++;
        end
        check_eq("push_accept", {31'd0, in_ready}, 32'd1);
        xq.push_back(x);
        if (expect_out) yq.push_back(x ^ 16'h1ABC);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (n_out < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        tick(8);
        check_eq(tag, n_out, target);
        check_eq("sb_empty", yq.size(), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("rst_fir_x", {16'd0, fir_x}, 32'd0);
        check_eq("rst_fir_act", {31'd0, fir_act}, 32'd0);
        check_eq("rst_out_y", {16'd0, out_y}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_level", {29'd0, fifo_level}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        xq.delete();
        yq.delete();
        tick(2);
        reset_n = 1'b1;
    endtask

    initial begin
        int base_act;
        int base_out;
        int k;
        cyc       = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        hang      = 1'b0;
        force_low = 1'b0;
        core_n    = 36;
        tick(2);
        apply_reset();
        tick(2);

        // Single sample, known result.
        push(16'h1000, 1'b1);
        drain("t2_out_count", 1, 200);
        check_eq("t2_acts", n_act, 32'd1);
        check_eq("t2_last_y", {16'd0, out_y}, 32'h0ABC);
        check_eq("t2_x_stable", n_unstable, 32'd0);

        // Six back-to-back samples overflow a four-entry FIFO.
        base_act = n_act;
        base_out = n_out;
        n_full   = 0;
        for (int i = 0; i < 6; i++) push(DW'(16'h2000 + i * 16'h0111), 1'b1);
        drain("t3_out_count", base_out + 6, 600);
        check_eq("t3_acts", n_act - base_act, 32'd6);
        check_eq("t3_saw_full", {31'd0, n_full > 0}, 32'd1);
        check_eq("t3_max_level", max_level, DEPTH);
        check_eq("t3_x_stable", n_unstable, 32'd0);

        // Core reports not ready: samples accumulate, nothing launched.
        base_act  = n_act;
        base_out  = n_out;
        force_low = 1'b1;
        push(16'h3333, 1'b1);
        push(16'h4444, 1'b1);
        tick(20);
        check_eq("t4_no_act", n_act - base_act, 32'd0);
        check_eq("t4_level", {29'd0, fifo_level}, 32'd2);
        check_eq("t4_busy", {31'd0, busy}, 32'd0);
        force_low = 1'b0;
        drain("t4_out_count", base_out + 2, 300);
        check_eq("t4_acts", n_act - base_act, 32'd2);

`ifdef FIR_DRV_TIMEOUT_EN
        // Core never answers: watchdog drops the sample and flags err.
        base_act = n_act;
        base_out = n_out;
        hang     = 1'b1;
        push(16'h5A5A, 1'b0);
        k = 0;
        while (n_act == base_act && k < 20) begin tick(1); k++; end
        check_eq("t5_act", n_act - base_act, 32'd1);
        k = 0;
        while (!err && k < 200) begin tick(1); k++; end
        check_eq("t5_err", {31'd0, err}, 32'd1);
        check_eq("t5_latency_ok", {31'd0, (cyc - t_act) >= 62 && (cyc - t_act) <= 66}, 32'd1);
        tick(2);
        check_eq("t5_busy", {31'd0, busy}, 32'd0);
        check_eq("t5_no_out", n_out - base_out, 32'd0);
        hang = 1'b0;
        k = 0;
        while (!fir_ready && k < 100) begin tick(1); k++; end
        push(16'h0F0F, 1'b1);
        drain("t5_out_count", base_out + 1, 200);
        check_eq("t5_err_sticky", {31'd0, err}, 32'd1);
`else
        check_eq("err_tied_low", {31'd0, err}, 32'd0);
`endif

        // Reset in the middle of a stream.
        for (int i = 0; i < 3; i++) push(DW'(16'h6000 + i), 1'b1);
        tick(5);
        apply_reset();
        base_act = n_act;
        base_out = n_out;
        tick(60);
        check_eq("t1_no_act", n_act - base_act, 32'd0);
        check_eq("t1_no_out", n_out - base_out, 32'd0);

        // Reset while waiting for the result with three samples queued.
        for (int i = 0; i < 4; i++) push(DW'(16'h7000 + i), 1'b1);
        k = 0;
        while (!(busy && !fir_ready && fifo_level == 3'd3) && k < 200) begin tick(1); k++; end
        check_eq("t6_reached_wait", {31'd0, busy && !fir_ready && fifo_level == 3'd3}, 32'd1);
        tick(3);
        apply_reset();
        base_act = n_act;
        base_out = n_out;
        tick(1);
        check_eq("t6_level", {29'd0, fifo_level}, 32'd0);
        check_eq("t6_busy", {31'd0, busy}, 32'd0);
        tick(60);
        check_eq("t6_no_stale_out", n_out - base_out, 32'd0);
        check_eq("t6_no_act", n_act - base_act, 32'd0);

        // Normal operation resumes after reset.
        push(16'h1234, 1'b1);
        drain("post_rst_out", base_out + 1, 200);
        check_eq("final_x_stable", n_unstable, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
